// File: rtl/ula_mc.sv
// ---------------------------------------------------------------------------
// ula_mc -- parametrised multi-cycle ALU
//
// Successor to the 8-bit combinational ALU. It uses the same 4-bit opcode map
// and adds unsigned divide and remainder.
//
// Timing:
//   - Logic, arithmetic, shift and rotate operations finish in one cycle.
//   - MUL, DIV and REM are iterative and take one step per cycle for WIDTH
//     cycles.
//
// Handshakes:
//   - Operands arrive over a valid/ready handshake.
//   - Results leave over a second valid/ready handshake.
//   - The result and its flags are registered and stay stable until the
//     consumer accepts them.
//
// Optional divider:
//   - Define ULA_MC_DIV_EN to build the divider for opcodes 1010/1011.
//   - Without it, those opcodes behave like undefined opcodes: single cycle,
//     s = 0.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept a new operation (IDLE)
//   a, b       operands
//   select     4-bit opcode
//   out_valid  s/flags hold a completed result (DONE)
//   out_ready  consumer accepts the result
//   s          result
//   flags      {N, Z, C, V}
// ---------------------------------------------------------------------------
module ula_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [3:0]       flags
);

  localparam int               MSB = WIDTH - 1;
  localparam int               CW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WL  = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] OP_NOT = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1100;
`ifdef ULA_MC_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_REM = 4'b1011;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             alive_q;
  logic             accept;
  logic             is_iter;
  logic             last_step;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
`ifdef ULA_MC_DIV_EN
  logic [3:0]       op_q;
`endif

  // single-cycle datapath
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] rot_amt;
  logic [WIDTH-1:0] alu_s;
  logic             alu_c;
  logic             alu_v;

  // iterative datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic [WIDTH-1:0] calc_s;
  logic             calc_c;
  logic             calc_v;
`ifdef ULA_MC_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  // Only MUL, and DIV/REM when the divider is built, take the CALC path.
`ifdef ULA_MC_DIV_EN
  assign is_iter = (select == OP_MUL) || (select == OP_DIV) || (select == OP_REM);
`else
  assign is_iter = (select == OP_MUL);
`endif

  assign last_step = (cnt_q == LAST_STEP);

  // State register.
  // alive_q holds in_ready low until the first clock edge after reset is
  // released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs.
  // Operands are accepted only from IDLE, so a consumed result can never be
  // followed by an acceptance in the same cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = alive_q;
        if (in_valid && alive_q) begin
          accept  = 1'b1;
          state_d = is_iter ? CALC : DONE;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle operations, computed straight from the input operands.
  // For the rotates, a rotate amount of zero makes the second shift equal
  // WIDTH. A shift by WIDTH gives zero, so the rotate returns a unchanged.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    rot_amt  = b % WL;
    alu_s    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (select)
      OP_NOT: alu_s = ~a;
      OP_AND: alu_s = a & b;
      OP_OR:  alu_s = a | b;
      OP_XOR: alu_s = a ^ b;
      OP_ADD: begin
        alu_s = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
        alu_v = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_s = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
      end
      OP_SLL: alu_s = (b >= WL) ? '0 : (a << b);
      OP_SRL: alu_s = (b >= WL) ? '0 : (a >> b);
      OP_ROL: alu_s = (a << rot_amt) | (a >> (WL - rot_amt));
      OP_ROR: alu_s = (a >> rot_amt) | (a << (WL - rot_amt));
      default: alu_s = '0;
    endcase
  end

  // One iteration of the multi-cycle operations.
  //
  // MUL is a right-shifting shift-add:
  //   - lo_q starts as operand a, the multiplier.
  //   - b_q is added into hi_q whenever the current multiplier bit is set.
  //   - After WIDTH steps, {hi_q, lo_q} holds the full product.
  //
  // DIV/REM is restoring division:
  //   - lo_q starts as the dividend and becomes the quotient.
  //   - hi_q is the partial remainder.
  //   - With b = 0 every trial subtraction succeeds. The quotient fills with
  //     ones and the remainder ends up equal to a, so divide-by-zero needs no
  //     special case.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    calc_hi = mul_sum[WIDTH:1];
    calc_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    calc_s  = calc_lo;
    calc_c  = |calc_hi;
    calc_v  = 1'b0;
`ifdef ULA_MC_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (op_q != OP_MUL) begin
      calc_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      calc_lo = {lo_q[WIDTH-2:0], div_ge};
      calc_s  = (op_q == OP_DIV) ? calc_lo : calc_hi;
      calc_c  = 1'b0;
      calc_v  = (b_q == '0);
    end
`endif
  end

  // Operand, iteration and result registers.
  // s and flags are written only when a result is produced, so they stay
  // stable while DONE waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
`ifdef ULA_MC_DIV_EN
      op_q  <= '0;
`endif
      s     <= '0;
      flags <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
`ifdef ULA_MC_DIV_EN
      op_q  <= select;
`endif
      if (!is_iter) begin
        s     <= alu_s;
        flags <= {alu_s[MSB], (alu_s == '0), alu_c, alu_v};
      end
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + CW'(1);
      hi_q  <= calc_hi;
      lo_q  <= calc_lo;
      if (last_step) begin
        s     <= calc_s;
        flags <= {calc_s[MSB], (calc_s == '0), calc_c, calc_v};
      end
    end
  end

endmodule

// File: tb/tb_ula_mc.sv
// ---------------------------------------------------------------------------
// tb_ula_mc -- self-checking bench for ula_mc (WIDTH = 8)
//
// The driver runs just after each rising edge. A scoreboard process samples
// on each falling edge.
//
// Every accepted operation is turned into an expected result by an
// arithmetic model of the opcode table, which also gives the expected
// latency. The result must appear exactly that many edges after acceptance
// and must stay stable while held. The block must return to IDLE on the
// edge after the result is consumed.
//
// Define ULA_MC_DIV_EN for both files to cover the divider build.
// ---------------------------------------------------------------------------
module tb_ula_mc;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic [3:0]   f;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   select;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic [3:0]   flags;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  logic prev_valid = 1'b0;
  logic consumed   = 1'b0;

  ula_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: the opcode table evaluated with plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   full, half, ia, ib, sa, sb, r, res, k;
    bit   c, v;
    full = 1 << W;
    half = full / 2;
    ia   = int'(av);
    ib   = int'(bv);
    sa   = (ia >= half) ? ia - full : ia;
    sb   = (ib >= half) ? ib - full : ib;
    k    = ib % W;
    res  = 0;
    c    = 1'b0;
    v    = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (op)
      4'd0: res = (full - 1) - ia;
      4'd1: res = ia & ib;
      4'd2: res = ia | ib;
      4'd3: res = ia ^ ib;
      4'd4: begin
        r   = ia + ib;
        res = r % full;
        c   = (r >= full);
        v   = ((sa + sb) > half - 1) || ((sa + sb) < -half);
      end
      4'd5: begin
        r   = ia - ib;
        res = (r + full) % full;
        c   = (ia < ib);
        v   = ((sa - sb) > half - 1) || ((sa - sb) < -half);
      end
      4'd6: res = (ib >= W) ? 0 : (ia << ib) % full;
      4'd7: res = (ib >= W) ? 0 : (ia >> ib);
      4'd8: begin
        r     = ia * ib;
        res   = r % full;
        c     = (r >= full);
        e.lat = W + 1;
      end
      4'd9:  res = ((ia << k) | (ia >> (W - k))) % full;
`ifdef ULA_MC_DIV_EN
      4'd10: begin
        res   = (ib == 0) ? full - 1 : ia / ib;
        v     = (ib == 0);
        e.lat = W + 1;
      end
      4'd11: begin
        res   = (ib == 0) ? ia : ia % ib;
        v     = (ib == 0);
        e.lat = W + 1;
      end
`endif
      4'd12: res = ((ia >> k) | (ia << (W - k))) % full;
      default: res = 0;
    endcase
    e.s = res[W-1:0];
    e.f = {(res >= half), (res == 0), c, v};
    return e;
  endfunction

  // Scoreboard: checks outputs every cycle against the queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      prev_valid = 1'b0;
      consumed   = 1'b0;
    end else begin
      if (consumed) begin
        checkOutput("idle_after_consume_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_after_consume_in_ready", 32'(in_ready), 32'd1);
      end
      consumed = 1'b0;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_valid) begin
            checkOutput("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
          end
          checkOutput("result_s", 32'(s), 32'(sbq[0].s));
          checkOutput("result_flags", 32'(flags), 32'(sbq[0].f));
          checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(sbq.pop_front());
            consumed = 1'b1;
          end
        end
      end else if (sbq.size() != 0) begin
        checkOutput("in_ready_while_busy", 32'(in_ready), 32'd0);
        if (cyc - sbq[0].acc >= sbq[0].lat) begin
          checkOutput("result_late", 32'(out_valid), 32'd1);
          void'(sbq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(select, a, b);
        e.acc = cyc;
        sbq.push_back(e);
      end
      prev_valid = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for its result, and hold it for holdCycles
  // with out_ready low while the inputs are scrambled. Then consume it with
  // in_valid random in that same cycle.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input int holdCycles, output logic [W-1:0] rs, output logic [3:0] rf);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) checkOutput("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    select   = op;
    a        = av;
    b        = bv;
    step();
    n = 0;
    while (!out_valid && n < 2 * W + 10) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      select   = 4'($urandom);
      step();
      n++;
    end
    if (!out_valid) checkOutput("wait_out_valid", 32'(out_valid), 32'd1);
    rs = s;
    rf = flags;
    for (int i = 0; i < holdCycles; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      select    = 4'($urandom);
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] rs;
    logic [3:0]   rf;
    logic [3:0]   op;
    logic [W-1:0] av, bv;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    select    = '0;

    // model pins (hand-computed)
    e = model(4'b0100, 8'hFF, 8'h01); checkOutput("pin_add_s", 32'(e.s), 32'h00); checkOutput("pin_add_f", 32'(e.f), 32'b0110);
    e = model(4'b0101, 8'h80, 8'h01); checkOutput("pin_sub_s", 32'(e.s), 32'h7F); checkOutput("pin_sub_f", 32'(e.f), 32'b0001);
    e = model(4'b1000, 8'h10, 8'h11); checkOutput("pin_mul1", {e.s, e.f}, {8'h10, 4'b0010});
    e = model(4'b1000, 8'h0F, 8'h0F); checkOutput("pin_mul2", {e.s, e.f}, {8'hE1, 4'b1000});
    e = model(4'b1001, 8'h81, 8'd9);  checkOutput("pin_rol", {e.s, e.f}, {8'h03, 4'b0000});
    e = model(4'b1100, 8'h81, 8'd1);  checkOutput("pin_ror", {e.s, e.f}, {8'hC0, 4'b1000});
    e = model(4'b0110, 8'h01, 8'd8);  checkOutput("pin_sll", {e.s, e.f}, {8'h00, 4'b0100});
    e = model(4'b0111, 8'h80, 8'd7);  checkOutput("pin_srl", {e.s, e.f}, {8'h01, 4'b0000});
`ifdef ULA_MC_DIV_EN
    e = model(4'b1010, 8'd200, 8'd7); checkOutput("pin_div", {e.s, e.f}, {8'h1C, 4'b0000});
    e = model(4'b1011, 8'd200, 8'd7); checkOutput("pin_rem", {e.s, e.f}, {8'h04, 4'b0000});
    e = model(4'b1010, 8'h55, 8'h00); checkOutput("pin_div0", {e.s, e.f}, {8'hFF, 4'b1001});
    e = model(4'b1011, 8'h55, 8'h00); checkOutput("pin_rem0", {e.s, e.f}, {8'h55, 4'b0001});
`else
    e = model(4'b1010, 8'd200, 8'd7); checkOutput("pin_div_off", {e.s, e.f, 8'(e.lat)}, {8'h00, 4'b0100, 8'd1});
`endif

    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_s", 32'(s), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // directed cases
    applyStimulus(4'b0100, 8'hFF, 8'h01, 0, rs, rf); checkOutput("dut_add", {rs, rf}, {8'h00, 4'b0110});
    applyStimulus(4'b0101, 8'h80, 8'h01, 1, rs, rf); checkOutput("dut_sub", {rs, rf}, {8'h7F, 4'b0001});
    applyStimulus(4'b1000, 8'h10, 8'h11, 5, rs, rf); checkOutput("dut_mul", {rs, rf}, {8'h10, 4'b0010});
    applyStimulus(4'b1000, 8'h0F, 8'h0F, 0, rs, rf); checkOutput("dut_mul2", {rs, rf}, {8'hE1, 4'b1000});
    applyStimulus(4'b1001, 8'h81, 8'd9, 0, rs, rf);  checkOutput("dut_rol", {rs, rf}, {8'h03, 4'b0000});
    applyStimulus(4'b1100, 8'h81, 8'd1, 0, rs, rf);  checkOutput("dut_ror", {rs, rf}, {8'hC0, 4'b1000});
    applyStimulus(4'b0110, 8'h01, 8'd8, 0, rs, rf);  checkOutput("dut_sll", {rs, rf}, {8'h00, 4'b0100});
    applyStimulus(4'b0111, 8'h80, 8'd7, 0, rs, rf);  checkOutput("dut_srl", {rs, rf}, {8'h01, 4'b0000});
`ifdef ULA_MC_DIV_EN
    applyStimulus(4'b1010, 8'd200, 8'd7, 0, rs, rf); checkOutput("dut_div", {rs, rf}, {8'h1C, 4'b0000});
    applyStimulus(4'b1011, 8'd200, 8'd7, 5, rs, rf); checkOutput("dut_rem", {rs, rf}, {8'h04, 4'b0000});
    applyStimulus(4'b1010, 8'h55, 8'h00, 0, rs, rf); checkOutput("dut_div0", {rs, rf}, {8'hFF, 4'b1001});
    applyStimulus(4'b1011, 8'h55, 8'h00, 0, rs, rf); checkOutput("dut_rem0", {rs, rf}, {8'h55, 4'b0001});
`else
    applyStimulus(4'b1010, 8'd200, 8'd7, 0, rs, rf); checkOutput("dut_div_off", {rs, rf}, {8'h00, 4'b0100});
`endif

    // reset asserted between edges in the 4th CALC cycle of a MUL
    applyStimulus(4'b0010, 8'h5A, 8'h01, 0, rs, rf);
    in_valid = 1'b1;
    select   = 4'b1000;
    a        = 8'h10;
    b        = 8'h11;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_s", 32'(s), 32'd0);
    checkOutput("midreset_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checkOutput("in_ready_after_midreset", 32'(in_ready), 32'd1);
    applyStimulus(4'b0100, 8'd3, 8'd4, 0, rs, rf);   checkOutput("dut_add_after_reset", {rs, rf}, {8'h07, 4'b0000});

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom);
      av = W'($urandom);
      bv = W'($urandom);
      if ($urandom_range(0, 3) == 0) bv = W'($urandom_range(0, 12));
      if ((op == 4'b1010 || op == 4'b1011) && $urandom_range(0, 4) == 0) bv = '0;
      applyStimulus(op, av, bv, int'($urandom_range(0, 3)), rs, rf);
    end

    repeat (3) step();
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
Name: ula_mc

Overview:
Parametrised, multi-cycle successor to the team's 8-bit combinational ALU. Keeps the same 4-bit opcode map and adds division and remainder. Multiply and divide are iterative. Operands are accepted and results returned over valid/ready handshakes. Status flags are registered with each result. Sits between the register-file read stage and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal values are 2 and above.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and opcode are valid.
in_ready  output  1  block can accept a new operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
select  input  4  opcode.
out_valid  output  1  s and flags hold a completed result.
out_ready  input  1  consumer accepts the result.
s  output  WIDTH  result.
flags  output  4  {N, Z, C, V}.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state=IDLE, out_valid=0, s=0, flags=0, internal counters and operand registers cleared.
  - in_ready=1 from the first edge after rst_n rises.
  - Reset mid-operation aborts the operation silently; no result is ever produced for it.
- States:
  - IDLE: in_ready=1.
  - CALC: iterative multiply or divide in progress; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- Transitions:
  - IDLE, accept (in_valid & in_ready): a, b and select are latched.
    - Opcodes 1000, 1010, 1011: go to CALC, counter=0.
    - All other opcodes: result computed; go to DONE next edge.
    - Latency is 1: out_valid rises on the edge after acceptance.
  - CALC: one shift-add (MUL) or restoring-subtract step (DIV/REM) per cycle. After WIDTH steps, go to DONE. out_valid rises exactly WIDTH+1 edges after acceptance.
  - DONE: s and flags stay stable while out_ready=0. On out_valid & out_ready, go to IDLE (out_valid=0 next edge). A new operation cannot be accepted in the same cycle.
- Inputs outside IDLE: in_valid is ignored; a, b and select may change freely without affecting the result.
- Opcodes:
  - 0000 NOT a.
  - 0001 AND.
  - 0010 OR.
  - 0011 XOR.
  - 0100 ADD.
  - 0101 SUB (a-b).
  - 0110 SLL a by b; result 0 if b>=WIDTH.
  - 0111 SRL (logical) a by b; result 0 if b>=WIDTH.
  - 1000 MUL; s = low WIDTH bits of the product.
  - 1001 ROL a by (b mod WIDTH); amount 0 returns a.
  - 1010 DIV, unsigned quotient.
  - 1011 REM, unsigned remainder.
  - 1100 ROR a by (b mod WIDTH).
  - 1101-1111: s=0.
- Flags:
  - N = s[WIDTH-1] for every opcode.
  - Z = (s==0) for every opcode.
  - C:
    - ADD: carry out.
    - SUB: borrow, i.e. 1 when a<b unsigned.
    - MUL: 1 when the high half of the 2*WIDTH product is nonzero.
    - All other opcodes: 0.
  - V:
    - ADD/SUB: two's-complement overflow.
    - DIV/REM with b=0: 1.
    - All other opcodes: 0.
- Divide by zero: still takes WIDTH cycles. DIV gives s = all ones; REM gives s = a; V=1.

Optional Feature:
- Macro: ULA_MC_DIV_EN.
- Defined: opcodes 1010/1011 are implemented as above, sharing the CALC counter with MUL.
- Undefined:
  - The divider datapath is absent.
  - 1010/1011 behave like an undefined opcode: single cycle, s=0, flags {0,1,0,0}.
  - MUL timing is unchanged.

Test Plan:
1. WIDTH=8, ADD a=0xFF b=0x01 -> s=0x00, flags N0 Z1 C1 V0, out_valid on the edge after accept. SUB a=0x80 b=0x01 -> s=0x7F, N0 Z0 C0 V1.
2. MUL a=0x10 b=0x11 -> in_ready=0 for 8 cycles, out_valid exactly 9 edges after accept, s=0x10, C=1. MUL 0x0F*0x0F -> s=0xE1, C=0, N=1.
3. ULA_MC_DIV_EN defined: DIV 200/7 -> s=0x1C; REM 200/7 -> s=0x04; DIV 0x55/0 -> s=0xFF, V=1; REM 0x55/0 -> s=0x55, V=1. Macro undefined: DIV 200/7 -> s=0x00, Z=1, 1-cycle latency.
4. Shifts and rotates: ROL 0x81 by 9 -> s=0x03; ROR 0x81 by 1 -> s=0xC0; SLL 0x01 by 8 -> s=0x00, Z=1; SRL 0x80 by 7 -> s=0x01.
5. Backpressure: hold out_ready=0 for 5 cycles after a result while toggling in_valid, a and select. Required: s, flags and out_valid stay stable; in_ready=0; no new operation is accepted. Raising out_ready returns the block to IDLE on the next edge.
6. Assert rst_n=0 asynchronously (between edges) on cycle 4 of a MUL. Required: out_valid=0 and s=0 immediately. After release, in_ready=1; ADD 3+4 then returns s=0x07 with no stale MUL result.
